// File: rtl/core_pkg.sv
// Shared core definitions: sequencer states, funct3 encodings, LSU FSM encoding.
// Latency: n/a (constants and pure helper functions only).
// Backpressure: n/a.
package core_pkg;

    // Core sequencer states the LSU cares about
    localparam logic [2:0] ST_DECODE = 3'd3;
    localparam logic [2:0] ST_MEM    = 3'd6;
    localparam logic [2:0] ST_WB     = 3'd7;

    // funct3 access size/sign encodings (stores use B/H/W only)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_DONE = 2'd2
    } lsu_state_e;

    // Legal size encodings differ between loads and stores
    function automatic logic f3_legal(input logic ld, input logic [2:0] f3);
        if (ld)
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
                   (f3 == F3_BU) || (f3 == F3_HU);
        else
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    endfunction

    // Halfwords need bit 0 clear, words need both low bits clear
    function automatic logic f3_misalign(input logic [2:0] f3, input logic [1:0] off);
        return (((f3 == F3_H) || (f3 == F3_HU)) && off[0]) ||
               ((f3 == F3_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: store strobe/data packing and load extraction/extension.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_align
    import core_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_off,
    input  logic [31:0] store_data,
    output logic [3:0]  st_wstrb,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    assign byte_sh = rdata >> {ld_off, 3'b000};
    assign half_sh = rdata >> {ld_off[1], 4'b0000};

    // Replicate the store value across lanes and enable only the addressed bytes
    always_comb begin
        st_wstrb = 4'hF;
        st_wdata = store_data;
        case (st_funct3)
            F3_B: begin
                st_wstrb = 4'b0001 << st_off;
                st_wdata = {4{store_data[7:0]}};
            end
            F3_H: begin
                st_wstrb = 4'b0011 << st_off;
                st_wdata = {2{store_data[15:0]}};
            end
            default: begin
                st_wstrb = 4'hF;
                st_wdata = store_data;
            end
        endcase
    end

    // Pull the addressed byte/half down to bit 0 and extend per funct3
    always_comb begin
        ld_data = rdata;
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            F3_BU:   ld_data = {24'h0, byte_sh[7:0]};
            F3_H:    ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
            F3_HU:   ld_data = {16'h0, half_sh[15:0]};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit: one outstanding req/ack data-memory access per memory-state visit.
// Latency: request registered on the issue edge; result/flags registered on the ack (or timeout) edge.
// Backpressure: busy stalls the sequencer until the access completes; waits indefinitely on mem_ack unless TIMEOUT != 0.
module lsu
    import core_pkg::*;
#(
    parameter logic [2:0] MEM_STATE = ST_MEM,
    parameter int         TIMEOUT   = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  state,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic [31:0] load_result,
    output logic        busy,
    output logic        misaligned,
    output logic        fault
);

    localparam int             CW     = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0]  TO_VAL = CW'(TIMEOUT);

    lsu_state_e    fsm;
    logic [CW-1:0] tmo_cnt;
    logic [CW-1:0] cnt_nxt;
    logic          timeout_hit;
    logic          acc;
    logic          ld;
    logic          misalign;
    logic          illegal;
    logic          ld_q;
    logic [1:0]    ld_off_q;
    logic [2:0]    ld_f3_q;
    logic [3:0]    st_wstrb;
    logic [31:0]   st_wdata;
    logic [31:0]   ld_data;

    // Load wins when both decode flags are set
    assign ld       = is_load;
    assign acc      = (state == MEM_STATE) && (is_load || is_store);
    assign misalign = f3_misalign(funct3, addr[1:0]);
    assign illegal  = !f3_legal(ld, funct3);
    assign busy     = acc && (fsm != LSU_DONE);

    assign cnt_nxt     = tmo_cnt + CW'(1);
    assign timeout_hit = (TIMEOUT != 0) && (cnt_nxt == TO_VAL);

    // Load extraction uses the offset/size captured at issue, not the live inputs
    lsu_align u_align (
        .st_funct3  (funct3),
        .st_off     (addr[1:0]),
        .store_data (store_data),
        .st_wstrb   (st_wstrb),
        .st_wdata   (st_wdata),
        .ld_funct3  (ld_f3_q),
        .ld_off     (ld_off_q),
        .rdata      (mem_rdata),
        .ld_data    (ld_data)
    );

    // Access sequencer: issue, wait for ack or timeout, then park until the core leaves MEM_STATE
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= LSU_IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= 32'h0;
            mem_wstrb   <= 4'h0;
            mem_wdata   <= 32'h0;
            load_result <= 32'h0;
            misaligned  <= 1'b0;
            fault       <= 1'b0;
            tmo_cnt     <= '0;
            ld_q        <= 1'b0;
            ld_off_q    <= 2'b00;
            ld_f3_q     <= 3'b000;
        end else begin
            case (fsm)
                LSU_IDLE: begin
                    if (acc) begin
                        if (misalign || illegal) begin
                            fsm         <= LSU_DONE;
                            misaligned  <= misalign;
                            fault       <= illegal;
                            load_result <= 32'h0;
                        end else begin
                            fsm        <= LSU_REQ;
                            mem_req    <= 1'b1;
                            mem_we     <= !ld;
                            mem_addr   <= {addr[31:2], 2'b00};
                            mem_wstrb  <= ld ? 4'h0 : st_wstrb;
                            mem_wdata  <= st_wdata;
                            tmo_cnt    <= '0;
                            misaligned <= 1'b0;
                            fault      <= 1'b0;
                            ld_q       <= ld;
                            ld_off_q   <= addr[1:0];
                            ld_f3_q    <= funct3;
                        end
                    end
                end
                LSU_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        if (ld_q)
                            load_result <= ld_data;
                        fsm <= LSU_DONE;
                    end else begin
                        tmo_cnt <= cnt_nxt;
                        if (timeout_hit) begin
                            fault       <= 1'b1;
                            mem_req     <= 1'b0;
                            load_result <= 32'h0;
                            fsm         <= LSU_DONE;
                        end
                    end
                end
                LSU_DONE: begin
                    if (state != MEM_STATE)
                        fsm <= LSU_IDLE;
                end
                default: fsm <= LSU_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table for single accesses plus hand sequences for late ack and reset.
// Latency: n/a.
// Backpressure: n/a.
module tb_lsu;
    import core_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  state = ST_DECODE;
    logic        is_load = 1'b0;
    logic        is_store = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] addr = 32'h0;
    logic [31:0] store_data = 32'h0;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata = 32'h0;
    logic        mem_ack = 1'b0;
    logic [31:0] load_result;
    logic        busy;
    logic        misaligned;
    logic        fault;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu #(.MEM_STATE(ST_MEM), .TIMEOUT(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .state       (state),
        .is_load     (is_load),
        .is_store    (is_store),
        .funct3      (funct3),
        .addr        (addr),
        .store_data  (store_data),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wstrb   (mem_wstrb),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ack     (mem_ack),
        .load_result (load_result),
        .busy        (busy),
        .misaligned  (misaligned),
        .fault       (fault)
    );

    typedef struct {
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] sd;
        logic [31:0] rdata;
        int          ack_dly;   // ack in this REQ cycle; 0 = never
        logic [31:0] e_addr;
        logic        e_we;
        logic [3:0]  e_wstrb;
        logic [31:0] e_wdata;
        logic [31:0] e_res;
        logic        e_mis;
        logic        e_flt;
        int          e_req;     // cycles mem_req is seen high
        int          e_busy;    // cycles busy is seen high
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic run_vec(input int id, input vec_t v);
        int  busy_cnt;
        int  req_cnt;
        bit  first;
        bit  done;
        busy_cnt = 0;
        req_cnt  = 0;
        first    = 1'b1;
        done     = 1'b0;
        @(posedge clk); #1;
        state      = ST_MEM;
        is_load    = v.ld;
        is_store   = v.st;
        funct3     = v.f3;
        addr       = v.addr;
        store_data = v.sd;
        for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clk);
            if (busy) begin
                busy_cnt++;
                if (mem_req) begin
                    if (first) begin
                        first = 1'b0;
                        chk($sformatf("v%0d_addr", id), mem_addr, v.e_addr);
                        chk($sformatf("v%0d_we", id), 32'(mem_we), 32'(v.e_we));
                        chk($sformatf("v%0d_wstrb", id), 32'(mem_wstrb), 32'(v.e_wstrb));
                        if (v.e_we)
                            chk($sformatf("v%0d_wdata", id), mem_wdata, v.e_wdata);
                    end
                    req_cnt++;
                    if (req_cnt == v.ack_dly) begin
                        mem_ack   = 1'b1;
                        mem_rdata = v.rdata;
                    end
                end
                @(posedge clk); #1;
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEADBEEF;
            end else begin
                done = 1'b1;
            end
        end
        chk($sformatf("v%0d_stall_bound", id), 32'(done), 32'd1);
        chk($sformatf("v%0d_busy_cycles", id), busy_cnt, v.e_busy);
        chk($sformatf("v%0d_req_cycles", id), req_cnt, v.e_req);
        chk($sformatf("v%0d_req_done", id), 32'(mem_req), 32'd0);
        chk($sformatf("v%0d_result", id), load_result, v.e_res);
        chk($sformatf("v%0d_misaligned", id), 32'(misaligned), 32'(v.e_mis));
        chk($sformatf("v%0d_fault", id), 32'(fault), 32'(v.e_flt));
        // Sequencer lingers in MEM_STATE: nothing may re-issue
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("v%0d_no_reissue", id), {31'h0, mem_req}, 32'd0);
            chk($sformatf("v%0d_no_restall", id), {31'h0, busy}, 32'd0);
        end
        @(posedge clk); #1;
        state = ST_WB;
        @(negedge clk);
        chk($sformatf("v%0d_wb_result", id), load_result, v.e_res);
        chk($sformatf("v%0d_wb_fault", id), 32'(fault), 32'(v.e_flt));
        @(posedge clk); #1;
        state    = ST_DECODE;
        is_load  = 1'b0;
        is_store = 1'b0;
    endtask

    initial begin
        //            ld    st    f3    addr          sd            rdata         dly e_addr        we    wstrb   wdata         res           mis   flt   req busy
        vecs[0]  = '{1'b1, 1'b0, F3_W,  32'h100, 32'h0,        32'h8899AABB, 3, 32'h100, 1'b0, 4'h0, 32'h0,        32'h8899AABB, 1'b0, 1'b0, 3, 4};
        vecs[1]  = '{1'b1, 1'b0, F3_B,  32'h103, 32'h0,        32'h80112233, 1, 32'h100, 1'b0, 4'h0, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 1, 2};
        vecs[2]  = '{1'b1, 1'b0, F3_BU, 32'h103, 32'h0,        32'h80112233, 2, 32'h100, 1'b0, 4'h0, 32'h0,        32'h00000080, 1'b0, 1'b0, 2, 3};
        vecs[3]  = '{1'b1, 1'b0, F3_HU, 32'h102, 32'h0,        32'h80112233, 1, 32'h100, 1'b0, 4'h0, 32'h0,        32'h00008011, 1'b0, 1'b0, 1, 2};
        vecs[4]  = '{1'b0, 1'b1, F3_H,  32'h206, 32'h1234ABCD, 32'h0,        1, 32'h204, 1'b1, 4'hC, 32'hABCDABCD, 32'h00008011, 1'b0, 1'b0, 1, 2};
        vecs[5]  = '{1'b1, 1'b0, F3_W,  32'h101, 32'h0,        32'h0,        0, 32'h0,   1'b0, 4'h0, 32'h0,        32'h0,        1'b1, 1'b0, 0, 1};
        vecs[6]  = '{1'b1, 1'b0, F3_H,  32'h102, 32'h0,        32'h80017FFF, 2, 32'h100, 1'b0, 4'h0, 32'h0,        32'hFFFF8001, 1'b0, 1'b0, 2, 3};
        vecs[7]  = '{1'b0, 1'b1, F3_B,  32'h301, 32'h000000A5, 32'h0,        1, 32'h300, 1'b1, 4'h2, 32'hA5A5A5A5, 32'hFFFF8001, 1'b0, 1'b0, 1, 2};
        vecs[8]  = '{1'b0, 1'b1, F3_W,  32'h40C, 32'hCAFEF00D, 32'h0,        2, 32'h40C, 1'b1, 4'hF, 32'hCAFEF00D, 32'hFFFF8001, 1'b0, 1'b0, 2, 3};
        vecs[9]  = '{1'b1, 1'b0, 3'b011, 32'h500, 32'h0,       32'h0,        0, 32'h0,   1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 0, 1};
        vecs[10] = '{1'b0, 1'b1, 3'b100, 32'h504, 32'h0,       32'h0,        0, 32'h0,   1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 0, 1};
        vecs[11] = '{1'b1, 1'b1, F3_H,  32'h0,   32'h55555555, 32'h12347FFE, 1, 32'h0,   1'b0, 4'h0, 32'h0,        32'h00007FFE, 1'b0, 1'b0, 1, 2};
        vecs[12] = '{1'b1, 1'b0, F3_W,  32'h600, 32'h0,        32'h11111111, 0, 32'h600, 1'b0, 4'h0, 32'h0,        32'h0,        1'b0, 1'b1, 4, 5};
        vecs[13] = '{1'b1, 1'b0, F3_B,  32'h1,   32'h0,        32'h00007F00, 1, 32'h0,   1'b0, 4'h0, 32'h0,        32'h0000007F, 1'b0, 1'b0, 1, 2};
        vecs[14] = '{1'b1, 1'b0, F3_W,  32'h800, 32'h0,        32'h0BADCAFE, 2, 32'h800, 1'b0, 4'h0, 32'h0,        32'h0BADCAFE, 1'b0, 1'b0, 2, 3};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_we", 32'(mem_we), 32'd0);
        chk("rst_addr", mem_addr, 32'h0);
        chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
        chk("rst_wdata", mem_wdata, 32'h0);
        chk("rst_result", load_result, 32'h0);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_fault", 32'(fault), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        for (int i = 0; i < 13; i++)
            run_vec(i, vecs[i]);

        // Late ack after a timeout must be ignored
        @(posedge clk); #1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        @(negedge clk);
        chk("late_ack_req", 32'(mem_req), 32'd0);
        chk("late_ack_fault", 32'(fault), 32'd1);
        chk("late_ack_result", load_result, 32'h0);

        run_vec(13, vecs[13]);

        // Reset in the middle of a request
        @(posedge clk); #1;
        state   = ST_MEM;
        is_load = 1'b1;
        funct3  = F3_W;
        addr    = 32'h700;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_issued", 32'(mem_req), 32'd1);
        rst      = 1'b1;
        state    = ST_DECODE;
        is_load  = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("mid_rst_req", 32'(mem_req), 32'd0);
        chk("mid_rst_result", load_result, 32'h0);
        rst       = 1'b0;
        mem_ack   = 1'b1;
        mem_rdata = 32'h12345678;
        @(posedge clk); #1;
        mem_ack   = 1'b0;
        @(negedge clk);
        chk("post_rst_ack_req", 32'(mem_req), 32'd0);
        chk("post_rst_ack_result", load_result, 32'h0);
        chk("post_rst_busy", 32'(busy), 32'd0);

        run_vec(14, vecs[14]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
